// File: rtl/sensor_pkg.sv
// sensor_pkg: definitions shared by the sensor monitor.
// Contents: the channel state enum, the sensor error rule function, and the
// widths of the sensor nibble and the persistence counter.
package sensor_pkg;

  localparam int unsigned SENS_W = 4;  // bits per channel: W=[3] X=[2] Y=[1] Z=[0]
  localparam int unsigned PCNT_W = 8;  // persistence counter width, covers PERSIST up to 255

  typedef enum logic [1:0] {
    ST_OK    = 2'd0,
    ST_PEND  = 2'd1,
    ST_FAULT = 2'd2
  } chan_state_e;

  // Raw error rule for one channel: Z | (Y & (W | X))
  function automatic logic sensor_rule(input logic [SENS_W-1:0] s);
    return s[0] | (s[1] & (s[3] | s[2]));
  endfunction

endpackage

// File: rtl/sensor_chan.sv
// sensor_chan: one monitored sensor channel. It evaluates the error rule,
// runs the OK/PEND/FAULT persistence FSM, and keeps a sticky fault flag.
// Ports:
//   i_clk, i_rst   clock and synchronous active-high reset
//   i_clear        returns the channel to OK and zeroes the persistence count
//   i_sensors      this channel's {W,X,Y,Z} nibble
//   o_raw_error_c  combinational rule result
//   o_enter_c      combinational; high in the cycle the channel will enter FAULT
//   o_fault        registered; high while the channel is in FAULT
module sensor_chan
  import sensor_pkg::*;
#(
  parameter int unsigned PERSIST = 3
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clear,
  input  logic [SENS_W-1:0] i_sensors,
  output logic              o_raw_error_c,
  output logic              o_enter_c,
  output logic              o_fault
);

  chan_state_e       r_state;
  chan_state_e       w_state_nxt;
  logic [PCNT_W-1:0] r_cnt;
  logic [PCNT_W-1:0] w_cnt_nxt;
  logic [PCNT_W-1:0] w_cnt_inc;
  logic              r_fault;
  logic              w_raw;

  assign w_raw         = sensor_rule(i_sensors);
  assign w_cnt_inc     = r_cnt + PCNT_W'(1);
  assign o_raw_error_c = w_raw;
  assign o_fault       = r_fault;
  // clear forces OK in the next-state logic, so entry is already suppressed by it
  assign o_enter_c     = (w_state_nxt == ST_FAULT) && (r_state != ST_FAULT);

  // State and counter registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_OK;
      r_cnt   <= '0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_fault <= (w_state_nxt == ST_FAULT);
    end
  end

  // Next-state and persistence counting
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (i_clear) begin
      w_state_nxt = ST_OK;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        ST_OK: begin
          if (w_raw) begin
            w_cnt_nxt   = PCNT_W'(1);
            w_state_nxt = (PERSIST == 1) ? ST_FAULT : ST_PEND;
          end
        end
        ST_PEND: begin
          if (w_raw) begin
            w_cnt_nxt = w_cnt_inc;
            if (w_cnt_inc == PCNT_W'(PERSIST)) begin
              w_state_nxt = ST_FAULT;
            end
          end else begin
            w_state_nxt = ST_OK;
            w_cnt_nxt   = '0;
          end
        end
        ST_FAULT: begin
          w_state_nxt = ST_FAULT;
        end
        default: begin
          w_state_nxt = ST_OK;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/sensor_mon.sv
// sensor_mon: multi-channel sensor fault monitor. There is one sensor_chan per
// channel. This module combines their results into an any-fault flag, a
// saturating count of fault-entry events, and a capture of the first faulting
// channel.
// Optional feature: macro SENSOR_MON_IRQ_EN adds the irq output, a registered
// one-cycle pulse in each cycle where at least one channel enters FAULT.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   sensors      4 bits per channel; channel c uses [4c+3:4c]
//   clear        clears latched faults and the first-fault capture
//   raw_error    combinational per-channel rule result
//   fault        registered sticky per-channel fault flags
//   fault_any    registered OR of fault
//   fault_count  registered saturating count of fault-entry events (clear does not reset it)
//   first_ch     registered index of the first channel to latch a fault
//   first_valid  registered; first_ch holds a captured index
//   irq          (SENSOR_MON_IRQ_EN only) fault-entry pulse
module sensor_mon
  import sensor_pkg::*;
#(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned PERSIST = 3,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [SENS_W*NUM_CH-1:0] sensors,
  input  logic                     clear,
  output logic [NUM_CH-1:0]        raw_error,
  output logic [NUM_CH-1:0]        fault,
  output logic                     fault_any,
  output logic [CNT_W-1:0]         fault_count,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] first_ch,
  output logic                     first_valid
`ifdef SENSOR_MON_IRQ_EN
  ,
  output logic                     irq
`endif
);

  localparam int unsigned ID_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned NUM_W = 5;  // holds up to 16 simultaneous entries
  localparam int unsigned SUM_W = CNT_W + NUM_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NUM_CH-1:0] w_enter;
  logic [NUM_CH-1:0] w_fault;
  logic [NUM_W-1:0]  w_enter_num;
  logic [ID_W-1:0]   w_first_idx;
  logic [SUM_W-1:0]  w_sum;
  logic [CNT_W-1:0]  w_count_nxt;

  logic              r_fault_any;
  logic [CNT_W-1:0]  r_count;
  logic [ID_W-1:0]   r_first_ch;
  logic              r_first_valid;

  assign fault       = w_fault;
  assign fault_any   = r_fault_any;
  assign fault_count = r_count;
  assign first_ch    = r_first_ch;
  assign first_valid = r_first_valid;

  // Per-channel rule, FSM and persistence counter
  for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
    sensor_chan #(
      .PERSIST(PERSIST)
    ) u_chan (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_clear      (clear),
      .i_sensors    (sensors[SENS_W*c +: SENS_W]),
      .o_raw_error_c(raw_error[c]),
      .o_enter_c    (w_enter[c]),
      .o_fault      (w_fault[c])
    );
  end

  // Count the entries this cycle and find the lowest entering index. The loop
  // runs downward so that the last match is the lowest index.
  always_comb begin
    w_enter_num = '0;
    w_first_idx = '0;
    for (int c = int'(NUM_CH) - 1; c >= 0; c--) begin
      if (w_enter[c]) begin
        w_enter_num = w_enter_num + NUM_W'(1);
        w_first_idx = ID_W'(c);
      end
    end
    w_sum       = SUM_W'(r_count) + SUM_W'(w_enter_num);
    w_count_nxt = (w_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : CNT_W'(w_sum);
  end

  // Aggregate registers; clear wins over a new capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fault_any   <= 1'b0;
      r_count       <= '0;
      r_first_ch    <= '0;
      r_first_valid <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      if (clear) begin
        r_fault_any   <= 1'b0;
        r_first_ch    <= '0;
        r_first_valid <= 1'b0;
      end else begin
        r_fault_any <= |(w_fault | w_enter);
        if (!r_first_valid && (|w_enter)) begin
          r_first_ch    <= w_first_idx;
          r_first_valid <= 1'b1;
        end
      end
    end
  end

`ifdef SENSOR_MON_IRQ_EN
  logic r_irq;

  assign irq = r_irq;

  // Fault-entry pulse, suppressed by clear and by rst
  always_ff @(posedge clk) begin
    if (rst) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= !clear && (|w_enter);
    end
  end
`endif

endmodule
